// File: rtl/priority_arbiter_4_if.sv
// Request/grant bundle for the 4-way priority arbiter.
// The requesting side uses the master modport; the arbiter uses the slave modport.
interface priority_arbiter_4_if;
  logic [3:0] req;      // request vector, bit n = requester n
  logic       done;     // owner release strobe
  logic       mode;     // 0 = fixed priority, 1 = round robin
  logic [3:0] gnt;      // one-hot grant, 0 when idle
  logic [1:0] y;        // index of current owner, 0 when idle
  logic       valid;    // grant active
  logic       timeout;  // one-cycle pulse on timeout revocation

  modport master (
    output req,
    output done,
    output mode,
    input  gnt,
    input  y,
    input  valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    input  mode,
    output gnt,
    output y,
    output valid,
    output timeout
  );
endinterface

// File: rtl/priority_arbiter_4.sv
// 4-requester arbiter with fixed-priority or round-robin selection.
// Two states: IDLE makes the selection, GRANT holds the owner until it
// releases (done), withdraws its request, or exhausts its TIMEOUT cycles.
// Every release is followed by one dead IDLE cycle. All outputs are registered.

// Property checker for the arbiter outputs; kept separate from the datapath.
module priority_arbiter_4_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [3:0] gnt,
  input logic [1:0] y,
  input logic       valid
);
  // Grant vector never carries more than one bit.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

  // While valid, the grant vector decodes the owner index.
  a_gnt_matches_y : assert property (@(posedge clk) disable iff (!rst_n)
    valid |-> (gnt == (4'b0001 << y)));

  // While idle, both grant and index read as zero.
  a_idle_zero : assert property (@(posedge clk) disable iff (!rst_n)
    !valid |-> ((gnt == 4'b0000) && (y == 2'b00)));
endmodule

module priority_arbiter_4 #(
  parameter int TIMEOUT = 8  // max consecutive grant cycles per owner, 1..255
) (
  input logic                 clk,
  input logic                 rst_n,
  priority_arbiter_4_if.slave bus
);

  // Last hold_cnt value an owner may reach before the grant is revoked.
  localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_r,    state_s;
  logic [3:0] gnt_r,      gnt_s;
  logic [1:0] y_r,        y_s;
  logic       valid_r,    valid_s;
  logic       timeout_r,  timeout_s;
  logic [7:0] hold_cnt_r, hold_cnt_s;
  logic [1:0] last_r,     last_s;

  logic [1:0] pick_s;
  logic       owner_req_s;
  logic       time_up_s;
  logic       release_s;

  // Highest set bit wins (bit 3 first); caller guarantees req is non-zero.
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] sel;
    if (r[3]) begin
      sel = 2'd3;
    end else if (r[2]) begin
      sel = 2'd2;
    end else if (r[1]) begin
      sel = 2'd1;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // First set bit searching last+1, last+2, last+3, last+4 (mod 4).
  // last+4 wraps back to last itself, so a sole requester can be re-granted.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    sel   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // One-hot decode of an owner index.
  function automatic logic [3:0] decode(input logic [1:0] idx);
    logic [3:0] v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // Candidate owner and release causes for the current cycle.
  always_comb begin
    if (bus.mode) begin
      pick_s = pick_rr(bus.req, last_r);
    end else begin
      pick_s = pick_fixed(bus.req);
    end
    owner_req_s = bus.req[y_r];
    time_up_s   = (hold_cnt_r == HOLD_MAX);
    release_s   = bus.done || !owner_req_s || time_up_s;
  end

  // Next-state and next-output decisions for the IDLE/GRANT machine.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    y_s        = y_r;
    valid_s    = valid_r;
    timeout_s  = 1'b0;
    hold_cnt_s = hold_cnt_r;
    last_s     = last_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req != 4'b0000) begin
          state_s    = ST_GRANT;
          y_s        = pick_s;
          gnt_s      = decode(pick_s);
          valid_s    = 1'b1;
          hold_cnt_s = 8'd0;
        end else begin
          state_s    = ST_IDLE;
          y_s        = 2'd0;
          gnt_s      = 4'b0000;
          valid_s    = 1'b0;
          hold_cnt_s = 8'd0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_s    = ST_IDLE;
          y_s        = 2'd0;
          gnt_s      = 4'b0000;
          valid_s    = 1'b0;
          hold_cnt_s = 8'd0;
          last_s     = y_r;
          // A coincident done or request withdrawal takes the blame instead.
          timeout_s  = time_up_s && !bus.done && owner_req_s;
        end else begin
          hold_cnt_s = hold_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        y_s        = 2'd0;
        gnt_s      = 4'b0000;
        valid_s    = 1'b0;
        hold_cnt_s = 8'd0;
        last_s     = 2'd3;
      end
    endcase
  end

  // State and output registers; reset clears the grant without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      gnt_r      <= 4'b0000;
      y_r        <= 2'd0;
      valid_r    <= 1'b0;
      timeout_r  <= 1'b0;
      hold_cnt_r <= 8'd0;
      last_r     <= 2'd3;
    end else begin
      state_r    <= state_s;
      gnt_r      <= gnt_s;
      y_r        <= y_s;
      valid_r    <= valid_s;
      timeout_r  <= timeout_s;
      hold_cnt_r <= hold_cnt_s;
      last_r     <= last_s;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.y       = y_r;
  assign bus.valid   = valid_r;
  assign bus.timeout = timeout_r;

  priority_arbiter_4_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .gnt   (gnt_r),
    .y     (y_r),
    .valid (valid_r)
  );

endmodule

// File: tb/tb_priority_arbiter_4.sv
// Bench for priority_arbiter_4: three instances (TIMEOUT 4, 2, 1) share the
// same stimulus and are each compared against a per-instance reference model
// that tracks the owner as an integer and counts granted cycles.
module tb_priority_arbiter_4;
  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic       mode = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  priority_arbiter_4_if bus0 ();
  priority_arbiter_4_if bus1 ();
  priority_arbiter_4_if bus2 ();

  assign bus0.req = req;  assign bus0.done = done;  assign bus0.mode = mode;
  assign bus1.req = req;  assign bus1.done = done;  assign bus1.mode = mode;
  assign bus2.req = req;  assign bus2.done = done;  assign bus2.mode = mode;

  priority_arbiter_4 #(.TIMEOUT(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  priority_arbiter_4 #(.TIMEOUT(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  priority_arbiter_4 #(.TIMEOUT(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  // Observation word per instance: {gnt, y, valid, timeout}
  logic [7:0] obs [ND];
  assign obs[0] = {bus0.gnt, bus0.y, bus0.valid, bus0.timeout};
  assign obs[1] = {bus1.gnt, bus1.y, bus1.valid, bus1.timeout};
  assign obs[2] = {bus2.gnt, bus2.y, bus2.valid, bus2.timeout};

  // Reference model: owner index (-1 = nobody), cycles granted so far,
  // previous owner, and the pending timeout flag.
  int owner [ND];
  int held  [ND];
  int last  [ND];
  bit tpulse[ND];

  function automatic int tlimit(input int d);
    if (d == 0) return 4;
    else if (d == 1) return 2;
    else return 1;
  endfunction

  function automatic logic [7:0] expv(input int d);
    logic [3:0] g;
    logic [1:0] yy;
    if (owner[d] < 0) return {4'b0000, 2'b00, 1'b0, tpulse[d]};
    g  = 4'(1 << owner[d]);
    yy = 2'(owner[d]);
    return {g, yy, 1'b1, tpulse[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      owner[d] = -1; held[d] = 0; last[d] = 3; tpulse[d] = 1'b0;
    end
  endtask

  task automatic model_clock();
    int c;
    bit up;
    for (int d = 0; d < ND; d++) begin
      tpulse[d] = 1'b0;
      if (owner[d] < 0) begin
        if (req != 4'b0000) begin
          c = -1;
          if (!mode) begin
            for (int b = 0; b < 4; b++) if (req[b]) c = b;
          end else begin
            for (int k = 4; k >= 1; k--) if (req[(last[d] + k) % 4]) c = (last[d] + k) % 4;
          end
          owner[d] = c;
          held[d]  = 1;
        end
      end else begin
        up = (held[d] == tlimit(d));
        if (done || !req[owner[d]] || up) begin
          tpulse[d] = up && !done && req[owner[d]];
          last[d]   = owner[d];
          owner[d]  = -1;
        end else begin
          held[d] = held[d] + 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_clock();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    req = 4'b0000; done = 1'b0; mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    req = 4'b1111; mode = 1'b1; done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs[d] !== 8'h00) begin
        errors++;
        $display("FAIL reset dut%0d got %h want 00", d, obs[d]);
      end
    end
    rst_n = 1'b1;
    req = 4'b0000;
    step();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs[d] !== expv(d)) begin
        errors++;
        $display("FAIL reset_idle dut%0d cyc%0d got %h want %h", d, cyc, obs[d], expv(d));
      end
    end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; req = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      step();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL fixed dut%0d cyc%0d got %h want %h", d, cyc, obs[d], expv(d));
        end
      end
      if (i == 0 || i == 2 || i == 4) begin
        checks++;
        if (bus0.gnt !== 4'b0100 || bus0.y !== 2'd2 || bus0.valid !== 1'b1) begin
          errors++;
          $display("FAIL fixed_grant i%0d got gnt=%b y=%0d v=%b want 0100/2/1", i, bus0.gnt, bus0.y, bus0.valid);
        end
      end
      if (i == 3) begin
        checks++;
        if (bus0.gnt !== 4'b0000 || bus0.valid !== 1'b0) begin
          errors++;
          $display("FAIL fixed_dead got gnt=%b v=%b want 0000/0", bus0.gnt, bus0.valid);
        end
      end
      done = (i == 2);
    end
    done = 1'b0;
  endtask

  task automatic test_round_robin();
    int seen[$];
    do_reset();
    mode = 1'b1; req = 4'b1111; done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL rr dut%0d cyc%0d got %h want %h", d, cyc, obs[d], expv(d));
        end
      end
      if (bus0.valid === 1'b1) seen.push_back(int'(bus0.y));
    end
    done = 1'b0;
    checks++;
    if (seen.size() != 5) begin
      errors++;
      $display("FAIL rr_count got %0d want 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] != (i % 4)) begin
          errors++;
          $display("FAIL rr_order idx%0d got %0d want %0d", i, seen[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int run;
    do_reset();
    mode = 1'b0; req = 4'b1000; done = 1'b0;
    step();
    run = 0;
    for (int i = 0; i < 10 && bus0.valid === 1'b1; i++) begin
      checks++;
      if (obs[0] !== expv(0)) begin
        errors++;
        $display("FAIL timeout_hold cyc%0d got %h want %h", cyc, obs[0], expv(0));
      end
      run++;
      step();
    end
    checks++;
    if (run != 4) begin
      errors++;
      $display("FAIL timeout_len got %0d want 4", run);
    end
    checks++;
    if (bus0.timeout !== 1'b1 || bus0.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_pulse got t=%b gnt=%b want 1/0000", bus0.timeout, bus0.gnt);
    end
    step();
    checks++;
    if (bus0.gnt !== 4'b1000 || bus0.timeout !== 1'b0 || obs[0] !== expv(0)) begin
      errors++;
      $display("FAIL timeout_regrant got %h want %h", obs[0], expv(0));
    end
  endtask

  task automatic test_withdraw();
    logic [3:0] pat [4];
    pat[0] = 4'b0010; pat[1] = 4'b1010; pat[2] = 4'b1000; pat[3] = 4'b1000;
    do_reset();
    mode = 1'b0; done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req = pat[i];
      step();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL withdraw dut%0d cyc%0d got %h want %h", d, cyc, obs[d], expv(d));
        end
      end
    end
    checks++;
    if (bus0.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL withdraw_next got gnt=%b want 1000", bus0.gnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b1; req = 4'b0100; done = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs[d] !== 8'h00) begin
        errors++;
        $display("FAIL async_reset dut%0d got %h want 00", d, obs[d]);
      end
    end
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs[d] !== expv(d) || obs[d][7:4] !== 4'b0001) begin
        errors++;
        $display("FAIL async_first dut%0d got %h want %h", d, obs[d], expv(d));
      end
    end
  endtask

  task automatic test_coincide();
    do_reset();
    mode = 1'b0; req = 4'b0001; done = 1'b0;
    step();
    done = 1'b1;
    step();
    checks++;
    if (bus1.timeout !== 1'b0 || bus1.valid !== 1'b0 || obs[1] !== expv(1)) begin
      errors++;
      $display("FAIL coincide got %h want %h", obs[1], expv(1));
    end
    done = 1'b0;
  endtask

  task automatic test_mode_change();
    do_reset();
    mode = 1'b0; req = 4'b1001; done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL mode_chg dut%0d cyc%0d got %h want %h", d, cyc, obs[d], expv(d));
        end
      end
      mode = 1'b1;
      done = (i == 1);
    end
    checks++;
    if (bus0.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mode_rr_pick got gnt=%b want 0001", bus0.gnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 7) == 0);
      mode = 1'($urandom_range(0, 1));
      step();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== expv(d)) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d got %h want %h", d, cyc, obs[d], expv(d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_timeout();
    test_withdraw();
    test_async_reset();
    test_coincide();
    test_mode_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
